// File: rtl/dm_responder_if.sv
// rtl/dm_responder_if.sv - request/response bundle between the MEM stage and dm_responder
interface dm_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_byteen;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, req_byteen,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, req_byteen,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/dm_responder.sv
// rtl/dm_responder.sv - single-outstanding data-memory responder with programmable wait
module dm_responder #(
    parameter int ADDR_WIDTH = 12,
    parameter int LATENCY    = 2
) (
    input  logic           clk,
    input  logic           reset,
    dm_responder_if.slave  bus
);
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam int CW    = $clog2(LATENCY + 2);
    localparam logic [CW-1:0] CNT_LOAD = CW'((LATENCY > 0) ? LATENCY - 1 : 0);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t          state, state_next;
    logic [CW-1:0]   cnt;
    logic            accept, commit;

    logic            wr_q;
    logic [31:2]     addr_q;
    logic [31:0]     wdata_q;
    logic [3:0]      be_q;

    logic            c_wr;
    logic [31:2]     c_addr;
    logic [31:0]     c_wdata;
    logic [3:0]      c_be;
    logic            oor;
    logic [ADDR_WIDTH-1:0] idx;

    logic [31:0]     rdata_q;
    logic            err_q;
    logic [31:0]     mem [DEPTH];

    assign accept = (state == IDLE) && bus.req_valid;

    // With LATENCY=0 the commit edge is the acceptance edge, so the live inputs are used.
    assign c_wr    = (state == IDLE) ? bus.req_write        : wr_q;
    assign c_addr  = (state == IDLE) ? bus.req_addr[31:2]   : addr_q;
    assign c_wdata = (state == IDLE) ? bus.req_wdata        : wdata_q;
    assign c_be    = (state == IDLE) ? bus.req_byteen       : be_q;
    assign oor     = |c_addr[31:ADDR_WIDTH+2];
    assign idx     = c_addr[ADDR_WIDTH+1:2];

    always_comb begin
        state_next = state;
        commit     = 1'b0;
        case (state)
            IDLE: begin
                if (bus.req_valid) begin
                    if (LATENCY == 0) begin
                        state_next = RESP;
                        commit     = 1'b1;
                    end else begin
                        state_next = WAIT;
                    end
                end
            end
            WAIT: begin
                if (cnt == '0) begin
                    state_next = RESP;
                    commit     = 1'b1;
                end
            end
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            cnt     <= '0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state <= state_next;
            if (accept) begin
                wr_q    <= bus.req_write;
                addr_q  <= bus.req_addr[31:2];
                wdata_q <= bus.req_wdata;
                be_q    <= bus.req_byteen;
                cnt     <= CNT_LOAD;
            end else if (state == WAIT) begin
                cnt <= cnt - 1'b1;
            end
            if (commit) begin
                err_q   <= oor;
                rdata_q <= (!oor && !c_wr) ? mem[idx] : 32'h0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (commit && c_wr && !oor) begin
            for (int b = 0; b < 4; b++)
                if (c_be[b]) mem[idx][8*b +: 8] <= c_wdata[8*b +: 8];
        end
    end

    assign bus.req_ready  = (state == IDLE);
    assign bus.resp_valid = (state == RESP);
    assign bus.resp_rdata = rdata_q;
    assign bus.resp_err   = err_q;
endmodule

// File: doc/dm_responder.md
# dm_responder

Memory-side responder for data-memory traffic from the pipeline's MEM stage. It accepts one load/store request at a time over a valid/ready handshake and services it against an internal word array after a programmable wait. It returns exactly one single-cycle response per request, with read data and an error flag. The MEM stage stalls from request issue until the response arrives, so this block can replace the fixed-latency single-cycle DM.

## Interface
- ADDR_WIDTH, 12, word-index width; array depth 2^ADDR_WIDTH words; valid byte range 0 .. 2^(ADDR_WIDTH+2)-1
- LATENCY, 2, wait cycles inserted between acceptance and response; 0 is legal
- clk  input  1  single clock; all state updates on rising edge
- reset  input  1  asynchronous, active-low; low clears all state immediately
- req_valid  input  1  request present
- req_ready  output  1  responder can accept; high only in IDLE
- req_write  input  1  1 = store, 0 = load
- req_addr  input  32  byte address; bits [1:0] ignored, word index = req_addr[ADDR_WIDTH+1:2]
- req_wdata  input  32  store data, lane-aligned
- req_byteen  input  4  store lane enables; bit i writes req_wdata[8i+7:8i]; ignored for loads
- resp_valid  output  1  response strobe, exactly one cycle per accepted request
- resp_rdata  output  32  load data (full word); 0 for stores and errors
- resp_err  output  1  request was out of range; meaningful only while resp_valid is high

## Operation
- States: IDLE, WAIT, RESP.
- IDLE: req_ready=1. On req_valid at a rising edge, the request is accepted. write, addr, wdata, and byteen are latched, and the inputs are don't-care afterwards. The next state is WAIT with the counter loaded to LATENCY-1, or RESP directly when LATENCY=0.
- WAIT: req_ready=0. The counter decrements each cycle. When the counter is 0, the next state is RESP.
- Entering RESP commits the access at that same edge:
  - In range, store: only enabled lanes of the word are updated.
  - In range, load: resp_rdata is registered from the array.
  - Out of range (any of req_addr[31:ADDR_WIDTH+2] nonzero): no array change, resp_rdata=0, resp_err=1.
- RESP: resp_valid=1 and req_ready=0 for one cycle. No backpressure. The next state is IDLE unconditionally.
- A load following a store to the same word observes the stored value.
- A store with byteen=0 completes normally with no array change and resp_err=0.
- Reset (low, any state) forces the following immediately:
  - state=IDLE, counter=0
  - resp_valid=0, resp_rdata=0, resp_err=0
  - all array words cleared to 0
  - any in-flight request is discarded and never committed.
- Reset values: req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0.

## Timing
- Request accepted at edge E, where req_valid=req_ready=1.
- The access commits at edge E+LATENCY.
- resp_valid is high in the cycle between edges E+LATENCY and E+LATENCY+1.
- req_ready returns high after edge E+LATENCY+1. The earliest next acceptance is edge E+LATENCY+2.
- Throughput is one request per LATENCY+2 cycles.
- resp_rdata and resp_err are registered. They hold their values until the next commit or reset.
- req_valid may stay high continuously. Each request is accepted only at an edge where req_ready=1, and never twice.

## Test plan
- Reset: drive reset low mid-simulation, then release. Required: req_ready=1, resp_valid=0, and a load of 0x0 returns resp_rdata=0x00000000, resp_err=0.
- Store/load, LATENCY=2: store 0x12345678 to 0x10 (byteen 1111) accepted at E. Required: resp_valid high only in cycle E+2..E+3, and req_ready low from E+1 to E+3. A load of 0x10 then returns 0x12345678.
- Byte lanes: after the previous test, store 0xAABBCCDD to 0x12 with byteen 0100. A load of 0x10 returns 0x12BB5678 (low address bits ignored).
- Out of range, ADDR_WIDTH=12: store 0xFFFFFFFF to 0x4000. Required: resp_err=1, resp_rdata=0. A load of 0x0 still returns its prior value.
- Reset during WAIT: accept a store of 0xDEADBEEF to 0x20, then pull reset low before E+2. Required: resp_valid never pulses, and after release a load of 0x20 returns 0.
- Back-to-back, LATENCY=0: hold req_valid high with two loads queued by the bench. Required: acceptances 2 cycles apart, exactly two resp_valid pulses, and req_ready=0 in each RESP cycle.
